seg_display_ctrl: RTL and testbench



---
 rtl/seg_disp_pkg.sv | 34 +++
 rtl/bin2bcd_seq.sv | 86 ++++++++
 rtl/seg_display_ctrl.sv | 116 +++++++++++
 tb/tb_seg_display_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared types, constants and the segment decoder for the seven-segment display path.
package seg_disp_pkg;

  typedef logic [7:0] seg_t;  // {dp,g,f,e,d,c,b,a}, active-low
  typedef logic [3:0] bcd_t;

  localparam seg_t SEG_BLANK = 8'hFF;
  localparam seg_t SEG_DASH  = 8'hBF;

  // Nibble to active-low cathode pattern; dp is always off.
  function automatic seg_t hex2seg(input bcd_t d);
    seg_t s;
    case (d)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter, one input bit per cycle.
// Ports: clk/rst_n; start (accepted only when idle), bin (sampled with start);
// busy (conversion in progress), done (one cycle, bcd valid), bcd (packed BCD digits).
module bin2bcd_seq #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned OUT_DIGITS = (DATA_W * 30103 + 99999) / 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*OUT_DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = 4 * OUT_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]   acc_q, acc_d, adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Add 3 to every digit >= 5 before the shift.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < int'(OUT_DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d   = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = (adj << 1) | BCD_W'(bin_q[DATA_W-1]);
        bin_d = {bin_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
    end
  end

  assign bcd = acc_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment controller: captures a value (hex or decimal via
// bin2bcd_seq), stores one nibble per digit and scans the digits on AN/CT.
// Ports: clk/rst_n; value_i/load_i/mode_i (capture), blank_lz_i (live leading-zero
// blanking), freeze_i (ignore loads); busy_o (decimal conversion running);
// AN (active-low digit enables), CT (active-low cathodes {dp,g,f,e,d,c,b,a}).
module seg_display_ctrl
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     value_i,
  input  logic                  load_i,
  input  logic                  mode_i,
  input  logic                  blank_lz_i,
  input  logic                  freeze_i,
  output logic                  busy_o,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [7:0]            CT
);

  localparam int unsigned TICK       = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int unsigned PRE_W      = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BCD_DIGITS = (DATA_W * 30103 + 99999) / 100000;
  localparam int unsigned STORE_W    = 4 * NUM_DIGITS;
  localparam int unsigned EXT_W      = 4 * (BCD_DIGITS + NUM_DIGITS);

  logic [PRE_W-1:0]           pre_q;
  logic                       tick;
  logic [IDX_W-1:0]           idx_q;
  logic [IDX_W-1:0]           msd;
  logic [NUM_DIGITS-1:0][3:0] store_q;
  logic                       ovf_q;
  logic                       load_ok;
  logic                       conv_start;
  logic                       conv_done;
  logic [4*BCD_DIGITS-1:0]    conv_bcd;
  logic [EXT_W-1:0]           bcd_ext;
  logic                       dec_ovf;
  seg_t                       seg_c;

  assign load_ok    = load_i && !freeze_i && !busy_o;
  assign conv_start = load_ok && mode_i;

  bin2bcd_seq #(
    .DATA_W    (DATA_W),
    .OUT_DIGITS(BCD_DIGITS)
  ) u_bin2bcd (
    .clk  (clk),
    .rst_n(rst_n),
    .start(conv_start),
    .bin  (value_i),
    .busy (busy_o),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  // Any converted digit beyond the display width means the value does not fit.
  assign bcd_ext = EXT_W'(conv_bcd);
  assign dec_ovf = |(bcd_ext >> STORE_W);

  // Digit store: hex loads write directly, decimal results land atomically on done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= '0;
      ovf_q   <= 1'b0;
    end else if (conv_done) begin
      store_q <= STORE_W'(conv_bcd);
      ovf_q   <= dec_ovf;
    end else if (load_ok && !mode_i) begin
      store_q <= STORE_W'(value_i);
      ovf_q   <= 1'b0;
    end
  end

  // Prescaler: one scan tick every TICK cycles.
  assign tick = (pre_q == PRE_W'(TICK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= tick ? '0 : pre_q + PRE_W'(1);
  end

  // Most significant nonzero digit; digit 0 is the floor so it is never blanked.
  always_comb begin
    msd = '0;
    for (int k = 1; k < int'(NUM_DIGITS); k++) begin
      if (store_q[k] != 4'h0) msd = IDX_W'(k);
    end
  end

  always_comb begin
    seg_c = hex2seg(store_q[idx_q]);
    if (ovf_q)                          seg_c = SEG_DASH;
    else if (blank_lz_i && idx_q > msd) seg_c = SEG_BLANK;
  end

  // idx_q names the digit driven at the next tick, so the first tick shows digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      AN    <= '1;
      CT    <= SEG_BLANK;
    end else if (tick) begin
      AN    <= ~(NUM_DIGITS'(1) << idx_q);
      CT    <= seg_c;
      idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl (8 digits, 32-bit data, TICK = 8).
module tb_seg_display_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] value_i;
  logic        load_i;
  logic        mode_i;
  logic        blank_lz_i;
  logic        freeze_i;
  logic        busy_o;
  logic [7:0]  an;
  logic [7:0]  ct;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         digit;
    logic [7:0] ct;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] an_q[$];
  logic [7:0] frame_ct[8];

  seg_display_ctrl #(
    .NUM_DIGITS(8),
    .DATA_W    (32),
    .CLK_HZ    (8000),
    .REFRESH_HZ(125)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_i   (value_i),
    .load_i    (load_i),
    .mode_i    (mode_i),
    .blank_lz_i(blank_lz_i),
    .freeze_i  (freeze_i),
    .busy_o    (busy_o),
    .AN        (an),
    .CT        (ct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Reference model: expected CT for each of the 8 digits pushed to the scoreboard.
  task automatic push_expected(input logic [31:0] v, input bit dec, input bit blk);
    logic [3:0]  dg[8];
    logic [31:0] t;
    bit          ovf;
    int          msd;
    exp_t        e;
    t = v;
    for (int k = 0; k < 8; k++) begin
      if (dec) begin
        dg[k] = 4'(t % 10);
        t     = t / 10;
      end else begin
        dg[k] = v[4*k +: 4];
      end
    end
    ovf = dec && (t != 0);
    msd = 0;
    for (int k = 0; k < 8; k++) if (dg[k] != 4'h0) msd = k;
    for (int k = 0; k < 8; k++) begin
      e.digit = k;
      if (ovf)                 e.ct = 8'hBF;
      else if (blk && k > msd) e.ct = 8'hFF;
      else                     e.ct = seg_of(dg[k]);
      sb_q.push_back(e);
    end
  endtask

  task automatic do_load(input logic [31:0] v, input bit m);
    value_i = v;
    mode_i  = m;
    load_i  = 1'b1;
    @(posedge clk); #1;
    load_i  = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy_o === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (busy_o === 1'b0);
  endtask

  // Wait for the scan to enter digit 0.
  task automatic sync_digit0(output bit ok);
    logic [7:0] prev;
    int         n = 0;
    ok   = 1'b0;
    prev = an;
    while (!ok && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (an !== prev && an === 8'hFE) ok = 1'b1;
      prev = an;
    end
  endtask

  // Record CT for each digit of one full scan frame into frame_ct.
  task automatic capture_frame(output bit ok);
    logic [7:0] prev;
    logic [7:0] oh;
    int         n;
    sync_digit0(ok);
    if (ok) begin
      frame_ct[0] = ct;
      for (int d = 1; d < 8; d++) begin
        prev = an;
        n    = 0;
        while (an === prev && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        oh = 8'h01 << d;
        if (an !== ~oh) ok = 1'b0;
        frame_ct[d] = ct;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (an !== 8'hFF) begin failures++; $display("FAIL reset_an got %h expected ff", an); end
    checks++; if (ct !== 8'hFF) begin failures++; $display("FAIL reset_ct got %h expected ff", ct); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", busy_o); end
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (an !== 8'hFF) begin failures++; $display("FAIL early_tick an got %h expected ff", an); end
    @(posedge clk); #1;
    checks++; if (an !== 8'hFE) begin failures++; $display("FAIL first_tick an got %h expected fe", an); end
    checks++; if (ct !== 8'hC0) begin failures++; $display("FAIL first_tick ct got %h expected c0", ct); end
  endtask

  // Starts right after the first tick has selected digit 0.
  task automatic test_free_run();
    logic [7:0] prev, oh, exp_an;
    int         n;
    for (int s = 1; s <= 8; s++) begin
      oh = 8'h01 << (s % 8);
      an_q.push_back(~oh);
    end
    while (an_q.size() != 0) begin
      prev = an;
      n    = 0;
      while (an === prev && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      exp_an = an_q.pop_front();
      checks++; if (an !== exp_an) begin failures++; $display("FAIL scan_an got %h expected %h", an, exp_an); end
      checks++; if (n != 8) begin failures++; $display("FAIL scan_period got %0d expected 8", n); end
    end
  endtask

  task automatic test_hex();
    bit   ok;
    exp_t e;
    for (int b = 1; b >= 0; b--) begin
      blank_lz_i = b[0];
      if (b == 1) do_load(32'h0000_00A5, 1'b0);
      push_expected(32'h0000_00A5, 1'b0, b[0]);
      capture_frame(ok);
      checks++; if (!ok) begin failures++; $display("FAIL hex_frame blank=%0d sync timeout", b); end
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (frame_ct[e.digit] !== e.ct) begin
          failures++;
          $display("FAIL hex_a5 blank=%0d digit%0d ct got %h expected %h", b, e.digit, frame_ct[e.digit], e.ct);
        end
      end
    end
  endtask

  task automatic test_decimal();
    bit   ok;
    int   n;
    exp_t e;
    blank_lz_i = 1'b1;
    do_load(32'd1234, 1'b1);
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      if (n == 10) begin
        value_i = 32'hFFFF;
        load_i  = 1'b1;
      end else begin
        load_i  = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    load_i = 1'b0;
    checks++; if (n != 33) begin failures++; $display("FAIL dec_busy_len got %0d expected 33", n); end
    push_expected(32'd1234, 1'b1, 1'b1);
    capture_frame(ok);
    checks++; if (!ok) begin failures++; $display("FAIL dec_frame sync timeout"); end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (frame_ct[e.digit] !== e.ct) begin
        failures++;
        $display("FAIL dec_1234 digit%0d ct got %h expected %h", e.digit, frame_ct[e.digit], e.ct);
      end
    end
  endtask

  // A hex load in the first cycle after busy falls must be accepted.
  task automatic test_back_to_back();
    bit   ok;
    exp_t e;
    blank_lz_i = 1'b1;
    do_load(32'd7, 1'b1);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_idle busy still %b", busy_o); end
    do_load(32'h3, 1'b0);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL b2b_hex_busy got %b expected 0", busy_o); end
    push_expected(32'h3, 1'b0, 1'b1);
    capture_frame(ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_frame sync timeout"); end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (frame_ct[e.digit] !== e.ct) begin
        failures++;
        $display("FAIL b2b digit%0d ct got %h expected %h", e.digit, frame_ct[e.digit], e.ct);
      end
    end
  endtask

  task automatic test_overflow();
    bit   ok;
    exp_t e;
    do_load(32'd100000000, 1'b1);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_idle busy still %b", busy_o); end
    for (int b = 1; b >= 0; b--) begin
      blank_lz_i = b[0];
      push_expected(32'd100000000, 1'b1, b[0]);
      capture_frame(ok);
      checks++; if (!ok) begin failures++; $display("FAIL ovf_frame blank=%0d sync timeout", b); end
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (frame_ct[e.digit] !== e.ct) begin
          failures++;
          $display("FAIL ovf_dash blank=%0d digit%0d ct got %h expected %h", b, e.digit, frame_ct[e.digit], e.ct);
        end
      end
    end
    blank_lz_i = 1'b1;
    do_load(32'h1, 1'b0);
    push_expected(32'h1, 1'b0, 1'b1);
    capture_frame(ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_clear_frame sync timeout"); end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (frame_ct[e.digit] !== e.ct) begin
        failures++;
        $display("FAIL ovf_clear digit%0d ct got %h expected %h", e.digit, frame_ct[e.digit], e.ct);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    bit   late;
    exp_t e;
    blank_lz_i = 1'b0;
    do_load(32'd4321, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL mid_busy_before got %b expected 1", busy_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mid_abort_busy got %b expected 0", busy_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mid_release_busy got %b expected 0", busy_o); end
    late = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy_o !== 1'b0) late = 1'b1;
    end
    checks++; if (late) begin failures++; $display("FAIL mid_late_busy got 1 expected 0"); end
    for (int f = 0; f < 2; f++) begin
      if (f == 1) begin
        freeze_i = 1'b1;
        do_load(32'h5, 1'b0);
        do_load(32'd99, 1'b1);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL freeze_busy got %b expected 0", busy_o); end
      end
      push_expected(32'h0, 1'b0, 1'b0);
      capture_frame(ok);
      checks++; if (!ok) begin failures++; $display("FAIL mid_frame%0d sync timeout", f); end
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (frame_ct[e.digit] !== e.ct) begin
          failures++;
          $display("FAIL mid_zero%0d digit%0d ct got %h expected %h", f, e.digit, frame_ct[e.digit], e.ct);
        end
      end
    end
    freeze_i = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b1;
    load_i     = 1'b0;
    mode_i     = 1'b0;
    value_i    = '0;
    blank_lz_i = 1'b0;
    freeze_i   = 1'b0;
    #2 rst_n   = 1'b0;
    test_reset();
    test_free_run();
    test_hex();
    test_decimal();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
